// File: rtl/subtrator_serial_pkg.sv
// Shared definitions for the serial add/subtract unit.
// This file holds the FSM state encodings and the op codes.
package subtrator_serial_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;

  // Counter width for a given number of digits; never narrower than one bit.
  function automatic int count_width(input int n_digits);
    return (n_digits > 1) ? $clog2(n_digits) : 1;
  endfunction

endpackage

// File: rtl/subtrator_serial_if.sv
// Request/result bundle of the serial add/subtract unit.
// The ALU controller holds the master side and the unit holds the slave side.
interface subtrator_serial_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic             op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] S;
  logic             C_out;
  logic             Z;
  logic             N;
  logic             V;

  modport master (
    output start, op, A, B,
    input  ready, valid, S, C_out, Z, N, V
  );

  modport slave (
    input  start, op, A, B,
    output ready, valid, S, C_out, Z, N, V
  );

endinterface

// File: rtl/subtrator_serial_celula.sv
// One digit of the serial datapath, built from DIGIT chained one-bit cells.
// Each cell acts as a full subtractor or as a full adder, depending on op.
module celula_serial
  import subtrator_serial_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             chain_in,
  input  logic             op,
  output logic [DIGIT-1:0] d,
  output logic             chain_out
);

  // The chain value carries a borrow for subtraction and a carry for addition.
  always_comb begin
    logic c;
    c = chain_in;
    d = '0;
    for (int i = 0; i < DIGIT; i++) begin
      d[i] = a[i] ^ b[i] ^ c;
      if (op == OP_ADD) begin
        c = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
      end else begin
        c = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c);
      end
    end
    chain_out = c;
  end

endmodule

// File: rtl/subtrator_serial.sv
// Multi-cycle add/subtract unit that processes DIGIT bits per clock, from LSB to MSB.
// It reports the result together with the carry/borrow, zero, negative and overflow flags.
module subtrator_serial
  import subtrator_serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic            clk,
  input  logic            rst,
  subtrator_serial_if.slave bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = count_width(NDIG);
  localparam logic [CW-1:0]    LAST     = CW'(NDIG - 1);
  localparam logic [WIDTH-1:0] DIG_MASK = WIDTH'({DIGIT{1'b1}});

  if ((WIDTH < 2) || (DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_params
    $error("subtrator_serial: DIGIT must divide WIDTH and WIDTH must be >= 2");
  end

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             chain;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             op_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] s_reg;
  logic             c_reg;
  logic             z_reg;
  logic             n_reg;
  logic             v_reg;

  logic [31:0]      shamt;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] dig_d;
  logic             chain_nxt;
  logic [WIDTH-1:0] res_next;
  logic             v_next;

  // Shifting instead of a variable part-select keeps the digit pick width-clean.
  always_comb begin
    shamt    = 32'(cnt) * DIGIT;
    a_dig    = DIGIT'(a_reg >> shamt);
    b_dig    = DIGIT'(b_reg >> shamt);
    res_next = (res_reg & ~(DIG_MASK << shamt)) | (WIDTH'(dig_d) << shamt);
    if (op_reg == OP_ADD) begin
      v_next = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) & (res_next[WIDTH-1] != a_reg[WIDTH-1]);
    end else begin
      v_next = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) & (res_next[WIDTH-1] != a_reg[WIDTH-1]);
    end
  end

  celula_serial #(.DIGIT(DIGIT)) u_celula (
    .a         (a_dig),
    .b         (b_dig),
    .chain_in  (chain),
    .op        (op_reg),
    .d         (dig_d),
    .chain_out (chain_nxt)
  );

  // The outputs and flags change only on the edge that completes the last digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      chain   <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      op_reg  <= OP_SUB;
      res_reg <= '0;
      s_reg   <= '0;
      c_reg   <= 1'b0;
      z_reg   <= 1'b0;
      n_reg   <= 1'b0;
      v_reg   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_reg   <= bus.A;
            b_reg   <= bus.B;
            op_reg  <= bus.op;
            chain   <= 1'b0;
            cnt     <= '0;
            res_reg <= '0;
            state   <= ST_CALC;
          end
        end
        ST_CALC: begin
          res_reg <= res_next;
          chain   <= chain_nxt;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            s_reg <= res_next;
            c_reg <= chain_nxt;
            z_reg <= ~|res_next;
            n_reg <= res_next[WIDTH-1];
            v_reg <= v_next;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready = (state == ST_IDLE);
  assign bus.valid = (state == ST_DONE);
  assign bus.S     = s_reg;
  assign bus.C_out = c_reg;
  assign bus.Z     = z_reg;
  assign bus.N     = n_reg;
  assign bus.V     = v_reg;

endmodule

// File: tb/tb_subtrator_serial.sv
// Self-checking bench for subtrator_serial with three instances: DIGIT=1, DIGIT=4 and DIGIT=8.
// A signed/unsigned arithmetic model predicts the result and the flags for each operation.
module tb_subtrator_serial;

  logic clk;
  logic rst;

  logic [2:0]      start_v;
  logic [2:0]      op_v;
  logic [2:0][7:0] a_v;
  logic [2:0][7:0] b_v;
  logic [2:0]      ready_v;
  logic [2:0]      valid_v;
  logic [2:0][11:0] res_v;

  int total;
  int bad;

  subtrator_serial_if #(.WIDTH(8)) bus1 ();
  subtrator_serial_if #(.WIDTH(8)) bus4 ();
  subtrator_serial_if #(.WIDTH(8)) bus8 ();

  subtrator_serial #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  subtrator_serial #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  subtrator_serial #(.WIDTH(8), .DIGIT(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  assign bus1.start = start_v[0];
  assign bus1.op    = op_v[0];
  assign bus1.A     = a_v[0];
  assign bus1.B     = b_v[0];
  assign bus4.start = start_v[1];
  assign bus4.op    = op_v[1];
  assign bus4.A     = a_v[1];
  assign bus4.B     = b_v[1];
  assign bus8.start = start_v[2];
  assign bus8.op    = op_v[2];
  assign bus8.A     = a_v[2];
  assign bus8.B     = b_v[2];

  assign ready_v = {bus8.ready, bus4.ready, bus1.ready};
  assign valid_v = {bus8.valid, bus4.valid, bus1.valid};
  assign res_v[0] = {bus1.S, bus1.C_out, bus1.Z, bus1.N, bus1.V};
  assign res_v[1] = {bus4.S, bus4.C_out, bus4.Z, bus4.N, bus4.V};
  assign res_v[2] = {bus8.S, bus8.C_out, bus8.Z, bus8.N, bus8.V};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Packed as {S, C_out, Z, N, V}, derived from integer arithmetic on the operand values.
  function automatic logic [11:0] ref_model(input logic op, input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb, ur, sr;
    logic [7:0] s;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    if (op) begin
      ur = ua + ub;
      sr = sa + sb;
      c  = (ur > 255);
    end else begin
      ur = ua - ub;
      sr = sa - sb;
      c  = (ua < ub);
    end
    s = 8'(ur & 255);
    v = (sr > 127) || (sr < -128);
    return {s, c, (s == 8'h00), s[7], v};
  endfunction

  function automatic int digits_of(input int idx);
    return (idx == 0) ? 8 : ((idx == 1) ? 2 : 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one request, scramble the operand inputs after the accept edge, and wait for valid.
  task automatic applyStimulus(input int idx, input logic op, input logic [7:0] a, input logic [7:0] b,
                               output int lat, output logic [11:0] res);
    @(negedge clk);
    checkOutput("ready_before_start", 32'(ready_v[idx]), 32'd1);
    start_v[idx] = 1'b1;
    op_v[idx]    = op;
    a_v[idx]     = a;
    b_v[idx]     = b;
    @(posedge clk);
    @(negedge clk);
    start_v[idx] = 1'b0;
    op_v[idx]    = ~op;
    a_v[idx]     = 8'($urandom);
    b_v[idx]     = 8'($urandom);
    checkOutput("ready_low_in_calc", 32'(ready_v[idx]), 32'd0);
    lat = 0;
    while (!valid_v[idx] && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    res = res_v[idx];
  endtask

  task automatic run_check(input int idx, input logic op, input logic [7:0] a, input logic [7:0] b);
    int lat;
    logic [11:0] res;
    applyStimulus(idx, op, a, b, lat, res);
    checkOutput($sformatf("result_d%0d_op%0d_%02h_%02h", idx, op, a, b), 32'(res), 32'(ref_model(op, a, b)));
    checkOutput($sformatf("latency_d%0d", idx), 32'(lat), 32'(digits_of(idx)));
    @(negedge clk);
    checkOutput("valid_single_cycle", 32'(valid_v[idx]), 32'd0);
    checkOutput("result_held", 32'(res_v[idx]), 32'(ref_model(op, a, b)));
  endtask

  logic [3:0]  dir_op;
  logic [31:0] dir_ab [4];

  initial begin
    int vcnt;
    logic [11:0] held;
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    start_v = '0;
    op_v    = '0;
    a_v     = '0;
    b_v     = '0;
    dir_op  = 4'b0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset_ready_%0d", i), 32'(ready_v[i]), 32'd1);
      checkOutput($sformatf("reset_valid_%0d", i), 32'(valid_v[i]), 32'd0);
      checkOutput($sformatf("reset_result_%0d", i), 32'(res_v[i]), 32'd0);
    end

    run_check(0, 1'b0, 8'h05, 8'h03);
    checkOutput("sub_05_03_S", 32'(res_v[0][11:4]), 32'h02);
    run_check(0, 1'b0, 8'h03, 8'h05);
    checkOutput("sub_03_05_C", 32'(res_v[0][3]), 32'd1);
    run_check(0, 1'b0, 8'h80, 8'h01);
    checkOutput("sub_80_01_V", 32'(res_v[0][0]), 32'd1);
    run_check(0, 1'b1, 8'hFF, 8'h01);
    checkOutput("add_FF_01_Z", 32'(res_v[0][2]), 32'd1);
    run_check(0, 1'b1, 8'h7F, 8'h01);
    checkOutput("add_7F_01_N", 32'(res_v[0][1]), 32'd1);

    // A start that arrives during CALC must be dropped rather than queued.
    @(negedge clk);
    start_v[0] = 1'b1; op_v[0] = 1'b0; a_v[0] = 8'h05; b_v[0] = 8'h03;
    @(posedge clk);
    vcnt = 0;
    held = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) start_v[0] = 1'b0;
      if (c == 2 || c == 3) begin
        start_v[0] = 1'b1; op_v[0] = 1'b1; a_v[0] = 8'hFF; b_v[0] = 8'h01;
      end
      if (c == 4) start_v[0] = 1'b0;
      if (valid_v[0]) begin
        vcnt++;
        held = res_v[0];
      end
    end
    checkOutput("ignored_start_valid_count", 32'(vcnt), 32'd1);
    checkOutput("ignored_start_result", 32'(held), 32'(ref_model(1'b0, 8'h05, 8'h03)));

    // Reset arrives in the third CALC cycle and must abort the operation.
    @(negedge clk);
    start_v[0] = 1'b1; op_v[0] = 1'b0; a_v[0] = 8'h5A; b_v[0] = 8'h33;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_mid_ready", 32'(ready_v[0]), 32'd1);
    checkOutput("rst_mid_valid", 32'(valid_v[0]), 32'd0);
    checkOutput("rst_mid_result", 32'(res_v[0]), 32'd0);
    vcnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (valid_v[0]) vcnt++;
    end
    checkOutput("rst_mid_no_valid", 32'(vcnt), 32'd0);
    run_check(0, 1'b0, 8'h5A, 8'h33);

    for (int n = 0; n < 100; n++) begin
      run_check(0, 1'($urandom), 8'($urandom), 8'($urandom));
    end
    for (int idx = 1; idx < 3; idx++) begin
      run_check(idx, 1'b0, 8'h80, 8'h01);
      run_check(idx, 1'b1, 8'hFF, 8'h01);
      for (int n = 0; n < 1000; n++) begin
        run_check(idx, 1'($urandom), 8'($urandom), 8'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
